// File: rtl/alu_pkg.sv
// Shared defaults and helpers for the ALU result pipeline.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_STAGES = 2;

    // Bits needed to count 0..stages held beats.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One ALU result pipeline stage: valid bit, result, zero/neg flags and the
// load condition that forms one link of the backward ready chain.
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_result_i,
    input  logic             up_zero_i,
    input  logic             up_neg_i,
    output logic             up_ready_o,
    input  logic             dn_ready_i,
    output logic             dn_valid_o,
    output logic [WIDTH-1:0] dn_result_o,
    output logic             dn_zero_o,
    output logic             dn_neg_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             load;

    // An empty stage, or one whose content is leaving this cycle, can take a new beat.
    assign load       = !valid_q || dn_ready_i;
    assign up_ready_o = load;

    // Next-state: capture upstream on load, hold otherwise; flush drops the valid bit.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        if (load) begin
            valid_d  = up_valid_i;
            result_d = up_result_i;
            zero_d   = up_zero_i;
            neg_d    = up_neg_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Stage registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign dn_valid_o  = valid_q;
    assign dn_result_o = result_q;
    assign dn_zero_o   = zero_q;
    assign dn_neg_o    = neg_q;

endmodule

// File: rtl/alu_result_pipe.sv
// Registered ALU result pipe: STAGES valid/ready stages carrying the result
// plus zero/neg flags computed at acceptance, with an occupancy counter.
module alu_result_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned STAGES = ALU_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic [3:0]       occupancy
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    // Index k is the input side of stage k; index STAGES is the pipe output.
    logic             vld [STAGES+1];
    logic             rdy [STAGES+1];
    logic [WIDTH-1:0] res [STAGES+1];
    logic             zf  [STAGES+1];
    logic             nf  [STAGES+1];

    assign vld[0]      = in_valid;
    assign res[0]      = in_result;
    assign zf[0]       = (in_result == '0);
    assign nf[0]       = in_result[WIDTH-1];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        alu_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush),
            .up_valid_i  (vld[k]),
            .up_result_i (res[k]),
            .up_zero_i   (zf[k]),
            .up_neg_i    (nf[k]),
            .up_ready_o  (rdy[k]),
            .dn_ready_i  (rdy[k+1]),
            .dn_valid_o  (vld[k+1]),
            .dn_result_o (res[k+1]),
            .dn_zero_o   (zf[k+1]),
            .dn_neg_o    (nf[k+1])
        );
    end

    assign in_ready   = rdy[0];
    assign out_valid  = vld[STAGES];
    assign out_result = res[STAGES];
    assign out_zero   = zf[STAGES];
    assign out_neg    = nf[STAGES];

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Occupancy next-state: flush wins, otherwise net of input and output transfers.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = 4'(occ_q);

endmodule

// File: tb/tb_alu_result_pipe.sv
// Self-checking bench for alu_result_pipe (WIDTH=32, STAGES=2): a stimulus
// table, directed corner sequences and random traffic against a queue model.
module tb_alu_result_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic [3:0]       occupancy;

    alu_result_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of accepted beats tagged with the step they were accepted.
    // The oldest beat is visible once STAGES steps have passed since its acceptance.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    logic  m_ir, m_ov;

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_result = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_now(input string tag);
        logic [WIDTH-1:0] hd;
        m_ov = (q.size() > 0) && ((cyc - q[0].t) >= int'(STAGES));
        m_ir = (q.size() < int'(STAGES)) || out_ready;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(m_ir));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(q.size()));
        if (m_ov) begin
            hd = q[0].d;
            chk({tag, ".out_result"}, 64'(out_result), 64'(hd));
            chk({tag, ".out_zero"},   64'(out_zero),   64'(hd == 0));
            chk({tag, ".out_neg"},    64'(out_neg),    64'(hd[WIDTH-1]));
        end
    endtask

    task automatic advance();
        logic ix, ox;
        beat_t b;
        ix = in_valid && m_ir;
        ox = m_ov && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) begin
                b.d = in_result;
                b.t = cyc;
                q.push_back(b);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                        input logic ordy, input logic fl);
        drive(iv, d, ordy, fl);
        #4;
        check_now(tag);
        advance();
    endtask

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             fl;
        logic             ev;
        logic [WIDTH-1:0] eres;
        logic             ez;
        logic             en;
        logic [3:0]       eocc;
        logic             eir;
    } vec_t;

    vec_t vt[6];
    int   delivered;
    int   accepted;

    initial begin
        // Streaming: hand-derived expected outputs sampled before each edge.
        vt[0] = '{1'b1, 32'h5,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b1};
        vt[1] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd1, 1'b1};
        vt[2] = '{1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h5,        1'b0, 1'b0, 4'd2, 1'b1};
        vt[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 4'd2, 1'b1};
        vt[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 4'd1, 1'b1};
        vt[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b1};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready",   64'(in_ready),   64'd1);
        chk("reset.out_valid",  64'(out_valid),  64'd0);
        chk("reset.out_result", 64'(out_result), 64'd0);
        chk("reset.occupancy",  64'(occupancy),  64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl);
            #4;
            chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(vt[i].ev));
            chk($sformatf("tbl%0d.occupancy", i), 64'(occupancy), 64'(vt[i].eocc));
            chk($sformatf("tbl%0d.in_ready", i),  64'(in_ready),  64'(vt[i].eir));
            if (vt[i].ev) begin
                chk($sformatf("tbl%0d.out_result", i), 64'(out_result), 64'(vt[i].eres));
                chk($sformatf("tbl%0d.out_zero", i),   64'(out_zero),   64'(vt[i].ez));
                chk($sformatf("tbl%0d.out_neg", i),    64'(out_neg),    64'(vt[i].en));
            end
            check_now($sformatf("tbl%0d.model", i));
            advance();
        end

        // Backpressure: third beat is refused, then all held beats drain in order.
        step("bp0", 1'b1, 32'hA1, 1'b0, 1'b0);
        step("bp1", 1'b1, 32'hA2, 1'b0, 1'b0);
        drive(1'b1, 32'hA3, 1'b0, 1'b0);
        #1;
        chk("bp.in_ready_full", 64'(in_ready),  64'd0);
        chk("bp.occ_full",      64'(occupancy), 64'd2);
        #3;
        check_now("bp2");
        advance();
        for (int i = 0; i < 4; i++) step($sformatf("bpdrain%0d", i), 1'b0, '0, 1'b1, 1'b0);

        // Full pass-through: accept and deliver every cycle while full.
        step("fp_fill0", 1'b1, 32'hB0, 1'b0, 1'b0);
        step("fp_fill1", 1'b1, 32'hB1, 1'b0, 1'b0);
        delivered = 0;
        accepted  = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0);
            #4;
            chk($sformatf("fp%0d.occ", i),      64'(occupancy), 64'd2);
            chk($sformatf("fp%0d.in_ready", i), 64'(in_ready),  64'd1);
            if (in_valid && in_ready) accepted++;
            if (out_valid && out_ready) delivered++;
            check_now($sformatf("fp%0d", i));
            advance();
        end
        chk("fp.accepted",  64'(accepted),  64'd4);
        chk("fp.delivered", 64'(delivered), 64'd4);
        for (int i = 0; i < 3; i++) step($sformatf("fpdrain%0d", i), 1'b0, '0, 1'b1, 1'b0);

        // Flush with two beats held and a third offered: nothing survives.
        step("fl_fill0", 1'b1, 32'hD0, 1'b0, 1'b0);
        step("fl_fill1", 1'b1, 32'hD1, 1'b0, 1'b0);
        step("fl_flush", 1'b1, 32'hDEAD, 1'b1, 1'b1);
        chk("fl.out_valid", 64'(out_valid), 64'd0);
        chk("fl.occupancy", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) step($sformatf("fl_after%0d", i), 1'b0, '0, 1'b1, 1'b0);

        // Mid-stream asynchronous reset, then the first edge after release accepts.
        step("mr0", 1'b1, 32'hE0, 1'b1, 1'b0);
        step("mr1", 1'b1, 32'hE1, 1'b1, 1'b0);
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr.out_valid",  64'(out_valid),  64'd0);
        chk("mr.out_result", 64'(out_result), 64'd0);
        chk("mr.occupancy",  64'(occupancy),  64'd0);
        chk("mr.in_ready",   64'(in_ready),   64'd1);
        q.delete();
        #1;
        rst = 1'b0;
        check_now("mr_release");
        advance();
        for (int i = 0; i < 3; i++) step($sformatf("mr_resume%0d", i), 1'b0, '0, 1'b1, 1'b0);

        // Random traffic with boundary-heavy data values.
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] d;
            case ($urandom_range(3))
                0:       d = '0;
                1:       d = 32'h80000000 | 32'($urandom);
                default: d = 32'($urandom) & 32'h7FFFFFFF;
            endcase
            step($sformatf("rnd%0d", i), 1'($urandom_range(1)), d,
                 1'($urandom_range(3) != 0), 1'($urandom_range(24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_pipe.md
ALU_RESULT_PIPE -- requirements
Module: alu_result_pipe

Interface
REQ-001 Parameter: WIDTH, 32, data width of the ALU result in bits; legal range 8..64.
REQ-002 Parameter: STAGES, 2, number of register stages between input and output; legal range 1..8.
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  in_result is valid this cycle.
REQ-006 Port: in_ready  output  1  pipe accepts a beat this cycle.
REQ-007 Port: in_result  input  WIDTH  ALU result to register.
REQ-008 Port: flush  input  1  synchronous discard of all held beats.
REQ-009 Port: out_valid  output  1  out_result, out_zero and out_neg are valid this cycle.
REQ-010 Port: out_ready  input  1  consumer accepts the output beat this cycle.
REQ-011 Port: out_result  output  WIDTH  registered ALU result.
REQ-012 Port: out_zero  output  1  the carried result equals 0.
REQ-013 Port: out_neg  output  1  the carried result has its MSB set (bit WIDTH-1).
REQ-014 Port: occupancy  output  4  number of valid beats held, 0..STAGES.

Function
REQ-015 A beat transfers on any edge where valid and ready are both high, at the input and at the output alike.
REQ-016 Stage k shall hold a valid bit, a WIDTH-bit result, a zero flag and a neg flag.
REQ-017 Stage k shall load when its valid bit is 0 or when stage k+1 accepts; stage STAGES-1 is downstream of out_ready.
REQ-018 in_ready shall equal the load condition of stage 0 (combinational backward ready chain, no bubble penalty).
REQ-019 out_valid and the output data shall come directly from the registers of stage STAGES-1, with no combinational path from in_* to out_*.
REQ-020 Latency shall be STAGES cycles: a beat accepted at edge t is presented at out_valid after edge t+STAGES-1, given no backpressure.
REQ-021 Throughput shall be one beat per cycle when out_ready is held high.
REQ-022 out_zero and out_neg shall be computed from in_result at acceptance and travel with the beat.
REQ-023 While out_valid=1 and out_ready=0, all output fields shall hold stable.
REQ-024 When a stage does not load, its data shall hold; a stage whose valid bit is 0 may have arbitrary data.
REQ-025 occupancy shall update each edge: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
REQ-026 flush=1 shall clear every valid bit and set occupancy to 0 at the next edge; any beat offered that cycle shall be discarded even if in_ready=1.
REQ-027 flush shall take priority over simultaneous input and output transfers; an output transfer in the flush cycle still counts as delivered.
REQ-028 When full (occupancy=STAGES) and out_ready=0, in_ready shall be 0.
REQ-029 When the pipe is full, out_ready=1 and in_valid=1, the pipe shall accept and deliver in the same cycle and occupancy shall stay at STAGES.

Reset
REQ-030 rst=1 shall immediately clear all valid bits, data, flags and occupancy to 0, including in the middle of an operation.
REQ-031 On reset, out_valid shall be 0 and in_ready shall be 1.
REQ-032 The first acceptance shall occur at the first edge after rst deasserts.

Structure
REQ-033 The default WIDTH and STAGES, and a function computing the occupancy width, shall reside in the shared package alu_pkg.
REQ-034 One stage shall be a sub-module, alu_pipe_stage (valid, data, flags, load logic), instantiated STAGES times by a generate loop.
REQ-035 The occupancy counter shall reside in the top level.

Verification (WIDTH=32, STAGES=2)
REQ-036 Scenario: streaming. Send 0x5, 0x0, 0x80000000 back-to-back with out_ready=1 -> each appears 2 cycles later. Required flags: (zero,neg) = (0,0), (1,0), (0,1); occupancy peaks at 2.
REQ-037 Scenario: backpressure. Hold out_ready=0 and send 3 beats -> only 2 accepted, in_ready=0 on the third, occupancy=2. Then raise out_ready -> beats emerge in order with none lost.
REQ-038 Scenario: full pass-through. Full pipe, out_ready=1 and in_valid=1 for 4 cycles -> 4 accepted, 4 delivered, occupancy constant at 2.
REQ-039 Scenario: flush. Flush with 2 beats held and a beat offered -> next cycle out_valid=0 and occupancy=0. The offered beat never appears.
REQ-040 Scenario: mid-stream reset. Assert rst asynchronously mid-stream -> out_valid=0, out_result=0 and occupancy=0 before the next edge. Normal operation resumes after deassert.
